// File: rtl/spi_cfg_master.sv
// SPI write master: queued {addr,data} requests leave as 16-bit mode-0 frames {1,addr,data}, MSB first.
// nCS falls 2 cycles after a push into an idle empty queue; req_ready drops while the request FIFO is full.
module spi_cfg_fifo #(
   parameter int W     = 15,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign dout  = mem_q[rd_q];

   // A push into a full FIFO is dropped, even in a pop cycle.
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + AW'(1);
      end
      if (do_pop) rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

module spi_cfg_master #(
   parameter int CLK_DIV    = 4,
   parameter int CS_SETUP   = 2,
   parameter int CS_IDLE    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_data,
   output logic       nCS,
   output logic       SCLK,
   output logic       copi,
   output logic       busy,
   output logic [7:0] frames_sent
);
   localparam int CW = $clog2(CLK_DIV + CS_SETUP + CS_IDLE);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd1;
   localparam logic [2:0] S_SCLK_HI = 3'd2;
   localparam logic [2:0] S_SCLK_LO = 3'd3;
   localparam logic [2:0] S_HOLD    = 3'd4;
   localparam logic [2:0] S_GAP     = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [14:0]   shift_q, shift_d;
   logic          ncs_q, ncs_d, sclk_q, sclk_d, copi_q, copi_d;
   logic [7:0]    frames_q, frames_d;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [14:0]   fifo_dout;

   spi_cfg_fifo #(.W(15), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_valid),
      .pop   (fifo_pop),
      .din   ({req_addr, req_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign req_ready   = !fifo_full;
   assign busy        = (state_q != S_IDLE) || !fifo_empty;
   assign nCS         = ncs_q;
   assign SCLK        = sclk_q;
   assign copi        = copi_q;
   assign frames_sent = frames_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      ncs_d    = ncs_q;
      sclk_d   = sclk_q;
      copi_d   = copi_q;
      frames_d = frames_q;
      fifo_pop = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d  = '0;
            ncs_d  = 1'b1;
            sclk_d = 1'b0;
            copi_d = 1'b0;
            // The write flag is the first bit out; shift_q holds the 15 bits behind it.
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               bit_d    = '0;
               ncs_d    = 1'b0;
               copi_d   = 1'b1;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               cnt_d   = '0;
               sclk_d  = 1'b1;
               state_d = S_SCLK_HI;
            end
         end
         S_SCLK_HI: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_d  = '0;
               sclk_d = 1'b0;
               if (bit_q == 4'd15) begin
                  state_d = S_HOLD;
               end else begin
                  copi_d  = shift_q[14];
                  shift_d = {shift_q[13:0], 1'b0};
                  bit_d   = bit_q + 4'd1;
                  state_d = S_SCLK_LO;
               end
            end
         end
         S_SCLK_LO: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_d   = '0;
               sclk_d  = 1'b1;
               state_d = S_SCLK_HI;
            end
         end
         S_HOLD: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_d    = '0;
               ncs_d    = 1'b1;
               copi_d   = 1'b0;
               frames_d = frames_q + 8'd1;
               state_d  = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == CW'(CS_IDLE - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            ncs_d   = 1'b1;
            sclk_d  = 1'b0;
            copi_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         ncs_q    <= 1'b1;
         sclk_q   <= 1'b0;
         copi_q   <= 1'b0;
         frames_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         ncs_q    <= ncs_d;
         sclk_q   <= sclk_d;
         copi_q   <= copi_d;
         frames_q <= frames_d;
      end
   end
endmodule
